servio_ram_arb: RTL
===================

# servio_ram_arb

Two-master arbiter and sequencer for the servio dual-port byte RAM (read port s0, write port s1). Two Wishbone-style requesters, typically the core data path and a debug/loader engine, share the RAM through this block. It serialises accesses, drives the RAM's read and write ports, and generates the write acknowledge that the RAM itself does not provide. It sits directly between the requesters and the RAM instance.

## Interface
Parameters:
- DATA_DEPTH, 1024, RAM depth in words. aw = $clog2(DATA_DEPTH).
- DATA_WIDTH, 8, data width dw.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- m0_adr / m1_adr  in  aw  requester address
- m0_cyc / m1_cyc  in  1  request, held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_dat / m1_dat  in  dw  write data
- m0_rdt / m1_rdt  out  dw  read data; ram_s0_rdt when that master's ack is high, else 0
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- ram_s0_adr  out  aw  RAM read address
- ram_s0_cyc  out  1  RAM read strobe
- ram_s0_rdt  in  dw  RAM read data
- ram_s0_ack  in  1  RAM read ack (registered in RAM, one cycle after cyc)
- ram_s1_adr  out  aw  RAM write address
- ram_s1_cyc  out  1  RAM write strobe
- ram_s1_we  out  1  RAM write enable
- ram_s1_dat  out  dw  RAM write data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR.
- IDLE: if any m*_cyc is high, the block grants one master. It latches the owner, adr, we and dat. The next state is WR if we=1, else RD_ISSUE.
- RD_ISSUE: ram_s0_cyc=1 and ram_s0_adr=latched adr for exactly one cycle, then RD_WAIT.
- RD_WAIT: ram_s0_cyc=0. When ram_s0_ack=1, the owner's ack=1 and its rdt=ram_s0_rdt (both combinational), then IDLE. If the ack has not arrived, the block stays in RD_WAIT.
- WR: ram_s1_cyc=ram_s1_we=1 with the latched adr/dat for exactly one cycle. The owner's ack=1 in the same cycle, then IDLE.
- Ack is gated by the owner's current cyc. If the owner drops cyc early, the RAM access still completes, no ack is issued, and the FSM returns to IDLE normally.
- The non-owner's ack and rdt are always 0. Only one ack can be high in any cycle.
- Latched RAM address/data outputs hold their last value while the corresponding cyc is low.
- Arbitration happens only in IDLE. A request arriving mid-transaction waits; it is never dropped.

## Timing
- Reset (async assert): state=IDLE; ram_s0_cyc, ram_s1_cyc, ram_s1_we, m0_ack, m1_ack, busy = 0; ram_s0_adr, ram_s1_adr, ram_s1_dat, m0_rdt, m1_rdt = 0; last-grant pointer = 1 (so m0 wins first).
- Reset mid-transaction aborts it: no ack is issued, and a write in WR during the reset edge is not committed (ram_s1_cyc forced low).
- Read: cyc seen in cycle T, RAM strobe in T+1, ack and rdt in T+2. Master holds cyc through T+2 and drops it in T+3.
- Write: cyc seen in cycle T, RAM write strobe and ack in T+1, data readable by a read granted at T+2 or later.
- Back-to-back: after the last ack the FSM is in IDLE the following cycle. Its throughput is one read per 3 cycles and one write per 2 cycles.
- Simultaneous requests in IDLE resolve according to the Configuration section.

## Configuration
- SERVIO_RAM_ARB_RR_EN defined: round-robin arbitration. On a tie, the master not granted last wins, and the pointer updates on every grant. Under continuous contention grants alternate m0, m1, m0, ...
- SERVIO_RAM_ARB_RR_EN undefined: fixed priority, where m0 always wins a tie. The pointer logic is absent, and m1 is served only when m0_cyc=0 in IDLE.

## Test plan
- Single read: preload RAM[0x010]=0xA5, then m0 reads 0x010. The bench requires ram_s0_cyc high in T+1 only, m0_ack=1 with m0_rdt=0xA5 in T+2, and m1_ack=0 throughout.
- Write then read: m1 writes 0x3C to 0x3FF (wrap-edge address), ack in T+1; m1 then reads 0x3FF and gets m1_rdt=0x3C.
- Contention, RR_EN defined: both masters read continuously from different addresses (m0 0x001=0x11, m1 0x002=0x22). Grants alternate m0, m1, m0, m1, with the first ack to m0 carrying 0x11. Without the macro, m1 gets no ack while m0 holds requests.
- Mixed contention: m0 writes and m1 reads in the same IDLE cycle. The write is acked at T+1 and the read acked at T+4; m1_rdt reflects the new data if the addresses match.
- Reset mid-write: assert reset during WR. All outputs go to 0 asynchronously, RAM contents at that address are unchanged, and the FSM is in IDLE after release.
- Early abort: m0 drops cyc in RD_ISSUE. No m0_ack is issued, busy clears after RD_WAIT, and a following m1 request is served normally.

Source files
------------

// File: rtl/servio_ram_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : servio_ram_arb_if
// Description : Bundle of the two requester buses and the servio dual-port
//               RAM ports seen by servio_ram_arb.
// Revision    : 1.0 - initial release
// ============================================================================
interface servio_ram_arb_if #(
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 8
);
    localparam int AW = $clog2(DATA_DEPTH);

    logic [AW-1:0]         m0_adr;
    logic                  m0_cyc;
    logic                  m0_we;
    logic [DATA_WIDTH-1:0] m0_dat;
    logic [DATA_WIDTH-1:0] m0_rdt;
    logic                  m0_ack;

    logic [AW-1:0]         m1_adr;
    logic                  m1_cyc;
    logic                  m1_we;
    logic [DATA_WIDTH-1:0] m1_dat;
    logic [DATA_WIDTH-1:0] m1_rdt;
    logic                  m1_ack;

    logic [AW-1:0]         ram_s0_adr;
    logic                  ram_s0_cyc;
    logic [DATA_WIDTH-1:0] ram_s0_rdt;
    logic                  ram_s0_ack;

    logic [AW-1:0]         ram_s1_adr;
    logic                  ram_s1_cyc;
    logic                  ram_s1_we;
    logic [DATA_WIDTH-1:0] ram_s1_dat;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  m0_adr, m0_cyc, m0_we, m0_dat,
        output m0_rdt, m0_ack,
        input  m1_adr, m1_cyc, m1_we, m1_dat,
        output m1_rdt, m1_ack,
        output ram_s0_adr, ram_s0_cyc,
        input  ram_s0_rdt, ram_s0_ack,
        output ram_s1_adr, ram_s1_cyc, ram_s1_we, ram_s1_dat,
        output busy
    );

    // Environment side: requesters plus the RAM instance
    modport master (
        output m0_adr, m0_cyc, m0_we, m0_dat,
        input  m0_rdt, m0_ack,
        output m1_adr, m1_cyc, m1_we, m1_dat,
        input  m1_rdt, m1_ack,
        input  ram_s0_adr, ram_s0_cyc,
        output ram_s0_rdt, ram_s0_ack,
        input  ram_s1_adr, ram_s1_cyc, ram_s1_we, ram_s1_dat,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/servio_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : servio_ram_arb
// Description : Two-master arbiter/sequencer for the servio dual-port byte RAM.
//               Define SERVIO_RAM_ARB_RR_EN for round-robin arbitration;
//               otherwise m0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module servio_ram_arb #(
    parameter int DATA_DEPTH = 1024,
    parameter int DATA_WIDTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    servio_ram_arb_if.slave bus
);
    localparam int AW = $clog2(DATA_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR       = 2'd3
    } state_t;

    state_t                state_q;
    logic                  owner_q;
    logic                  busy_q;
    logic                  s0_cyc_q;
    logic [AW-1:0]         s0_adr_q;
    logic                  s1_cyc_q;
    logic                  s1_we_q;
    logic [AW-1:0]         s1_adr_q;
    logic [DATA_WIDTH-1:0] s1_dat_q;

    logic                  grant_m1;
    logic                  any_req;
    logic [AW-1:0]         sel_adr;
    logic                  sel_we;
    logic [DATA_WIDTH-1:0] sel_dat;
    logic                  owner_cyc;
    logic                  done;
    logic                  ack_any;

`ifdef SERVIO_RAM_ARB_RR_EN
    // Set when the most recent grant went to m1; resets to 1 so m0 wins first.
    logic last_m1_q;
    assign grant_m1 = bus.m1_cyc & (~bus.m0_cyc | ~last_m1_q);
`else
    assign grant_m1 = bus.m1_cyc & ~bus.m0_cyc;
`endif

    assign any_req = bus.m0_cyc | bus.m1_cyc;
    assign sel_adr = grant_m1 ? bus.m1_adr : bus.m0_adr;
    assign sel_we  = grant_m1 ? bus.m1_we  : bus.m0_we;
    assign sel_dat = grant_m1 ? bus.m1_dat : bus.m0_dat;

    // An owner that has withdrawn its request is never acknowledged.
    assign owner_cyc = owner_q ? bus.m1_cyc : bus.m0_cyc;
    assign done      = (state_q == WR) || ((state_q == RD_WAIT) && bus.ram_s0_ack);
    assign ack_any   = done && owner_cyc;

    assign bus.m0_ack = ack_any & ~owner_q;
    assign bus.m1_ack = ack_any &  owner_q;
    assign bus.m0_rdt = bus.m0_ack ? bus.ram_s0_rdt : '0;
    assign bus.m1_rdt = bus.m1_ack ? bus.ram_s0_rdt : '0;

    assign bus.ram_s0_cyc = s0_cyc_q;
    assign bus.ram_s0_adr = s0_adr_q;
    assign bus.ram_s1_cyc = s1_cyc_q;
    assign bus.ram_s1_we  = s1_we_q;
    assign bus.ram_s1_adr = s1_adr_q;
    assign bus.ram_s1_dat = s1_dat_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            busy_q    <= 1'b0;
            s0_cyc_q  <= 1'b0;
            s0_adr_q  <= '0;
            s1_cyc_q  <= 1'b0;
            s1_we_q   <= 1'b0;
            s1_adr_q  <= '0;
            s1_dat_q  <= '0;
`ifdef SERVIO_RAM_ARB_RR_EN
            last_m1_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q <= grant_m1;
                        busy_q  <= 1'b1;
`ifdef SERVIO_RAM_ARB_RR_EN
                        last_m1_q <= grant_m1;
`endif
                        if (sel_we) begin
                            s1_cyc_q <= 1'b1;
                            s1_we_q  <= 1'b1;
                            s1_adr_q <= sel_adr;
                            s1_dat_q <= sel_dat;
                            state_q  <= WR;
                        end else begin
                            s0_cyc_q <= 1'b1;
                            s0_adr_q <= sel_adr;
                            state_q  <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    s0_cyc_q <= 1'b0;
                    state_q  <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.ram_s0_ack) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                WR: begin
                    s1_cyc_q <= 1'b0;
                    s1_we_q  <= 1'b0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
